// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the asynchronous PS/2 lines, frames 11-bit
// serial bytes and decodes set-2 make/break codes into held-key levels.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       w_key,
  output logic       s_key,
  output logic       up_key,
  output logic       down_key,
  output logic       space_key,
  output logic [7:0] keycode,
  output logic       keycode_ext,
  output logic       keycode_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          ext, brk;

  assign fall = filt_prev & ~filt_clk;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= PS2_CLK;
      clk_s2    <= clk_s1;
      dat_s1    <= PS2_DAT;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      // Any sample agreeing with the current filtered level restarts the run.
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bitcnt        <= '0;
      par_ok        <= 1'b0;
      to_cnt        <= '0;
      byte_valid    <= 1'b0;
      byte_data     <= '0;
      ext           <= 1'b0;
      brk           <= 1'b0;
      w_key         <= 1'b0;
      s_key         <= 1'b0;
      up_key        <= 1'b0;
      down_key      <= 1'b0;
      space_key     <= 1'b0;
      keycode       <= '0;
      keycode_ext   <= 1'b0;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      byte_valid    <= 1'b0;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;

      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, dat_s2};
            state  <= STOP;
          end
          STOP: begin
            if (dat_s2 && par_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // A byte is decoded the cycle after its stop bit; no fall or timeout can coincide.
      if (byte_valid) begin
        if (byte_data == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_data == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext && !brk &&
              (byte_data == 8'hAA || byte_data == 8'h00 || byte_data == 8'hFF)) begin
            w_key     <= 1'b0;
            s_key     <= 1'b0;
            up_key    <= 1'b0;
            down_key  <= 1'b0;
            space_key <= 1'b0;
          end else begin
            case ({ext, byte_data})
              9'h01D:  w_key     <= !brk;
              9'h01B:  s_key     <= !brk;
              9'h029:  space_key <= !brk;
              9'h175:  up_key    <= !brk;
              9'h172:  down_key  <= !brk;
              default: ;
            endcase
          end
          if (!brk) begin
            keycode       <= byte_data;
            keycode_ext   <= ext;
            keycode_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and checks key
// levels, keycode reporting, latency, error pulses and reset behaviour.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 300;
  localparam int HALF = 20;
  // Sync flop + FILT filter samples + byte register + decode register.
  localparam int LAT     = FILT + 3;
  localparam int LAT_ERR = FILT + 2;

  logic       Clk, Reset, PS2_CLK, PS2_DAT;
  logic       w_key, s_key, up_key, down_key, space_key;
  logic [7:0] keycode;
  logic       keycode_ext, keycode_valid, frame_err;
  logic [4:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int lat_valid, lat_err, lat_keys;

  assign keys = {w_key, s_key, up_key, down_key, space_key};

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .w_key(w_key), .s_key(s_key), .up_key(up_key), .down_key(down_key),
    .space_key(space_key), .keycode(keycode), .keycode_ext(keycode_ext),
    .keycode_valid(keycode_valid), .frame_err(frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (keycode_valid) n_valid++;
    if (frame_err)     n_err++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    logic [4:0] k0;
    for (int k = 0; k < nbits; k++) begin
      PS2_DAT = fr[k];
      repeat (HALF) @(negedge Clk);
      PS2_CLK   = 1'b0;
      k0        = keys;
      lat_valid = -1;
      lat_err   = -1;
      lat_keys  = -1;
      for (int i = 0; i < HALF; i++) begin
        @(negedge Clk);
        if (keycode_valid && lat_valid < 0) lat_valid = i;
        if (frame_err && lat_err < 0)       lat_err = i;
        if (keys !== k0 && lat_keys < 0)    lat_keys = i;
      end
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_parity);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    send_bits(fr, 11);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++;
    if ({keys, keycode, keycode_ext, keycode_valid, frame_err} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0000",
               {keys, keycode, keycode_ext, keycode_valid, frame_err});
    end
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_make_w;
    int v0;
    v0 = n_valid;
    send_byte(8'h1D, 1'b0);
    n_checks++; if (w_key !== 1'b1) begin n_fail++; $display("FAIL make_w_key: got %b required 1", w_key); end
    n_checks++; if (keycode !== 8'h1D) begin n_fail++; $display("FAIL make_w_keycode: got %h required 1d", keycode); end
    n_checks++; if (keycode_ext !== 1'b0) begin n_fail++; $display("FAIL make_w_ext: got %b required 0", keycode_ext); end
    n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL make_w_valid_count: got %0d required 1", n_valid - v0); end
    n_checks++; if (lat_valid !== LAT) begin n_fail++; $display("FAIL make_w_valid_latency: got %0d required %0d", lat_valid, LAT); end
    n_checks++; if (lat_keys !== LAT) begin n_fail++; $display("FAIL make_w_key_latency: got %0d required %0d", lat_keys, LAT); end
  endtask

  task automatic test_break_w;
    int v0;
    v0 = n_valid;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    n_checks++; if (w_key !== 1'b0) begin n_fail++; $display("FAIL break_w_key: got %b required 0", w_key); end
    n_checks++; if (lat_keys !== LAT) begin n_fail++; $display("FAIL break_w_latency: got %0d required %0d", lat_keys, LAT); end
    n_checks++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL break_w_valid_count: got %0d required 0", n_valid - v0); end
  endtask

  task automatic test_ext_up;
    int v0;
    v0 = n_valid;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    n_checks++; if (up_key !== 1'b1) begin n_fail++; $display("FAIL ext_up_make: got %b required 1", up_key); end
    n_checks++; if ({keycode_ext, keycode} !== 9'h175) begin n_fail++; $display("FAIL ext_up_keycode: got %h required 175", {keycode_ext, keycode}); end
    n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL ext_up_valid_count: got %0d required 1", n_valid - v0); end
    v0 = n_valid;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    n_checks++; if (up_key !== 1'b0) begin n_fail++; $display("FAIL ext_up_break: got %b required 0", up_key); end
    n_checks++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL ext_up_break_valid: got %0d required 0", n_valid - v0); end
    n_checks++; if ({keycode_ext, keycode} !== 9'h175) begin n_fail++; $display("FAIL ext_up_keycode_hold: got %h required 175", {keycode_ext, keycode}); end
  endtask

  task automatic test_parity_err;
    int e0;
    e0 = n_err;
    send_byte(8'h1B, 1'b1);
    n_checks++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL parity_err_count: got %0d required 1", n_err - e0); end
    n_checks++; if (lat_err !== LAT_ERR) begin n_fail++; $display("FAIL parity_err_latency: got %0d required %0d", lat_err, LAT_ERR); end
    n_checks++; if (s_key !== 1'b0) begin n_fail++; $display("FAIL parity_err_s_key: got %b required 0", s_key); end
    send_byte(8'h1B, 1'b0);
    n_checks++; if (s_key !== 1'b1) begin n_fail++; $display("FAIL parity_recover_s_key: got %b required 1", s_key); end
    n_checks++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL parity_recover_err_count: got %0d required 1", n_err - e0); end
  endtask

  task automatic test_timeout;
    int e0, t;
    logic [7:0]  b;
    logic [10:0] fr;
    b  = 8'h72;
    fr = {1'b1, ~^b, b, 1'b0};
    send_byte(8'hE0, 1'b0);
    e0 = n_err;
    t  = -1;
    send_bits(fr, 5);
    for (int j = 0; j < TMO + 100; j++) begin
      @(negedge Clk);
      if (frame_err && t < 0) t = HALF + j;
    end
    n_checks++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d required 1", n_err - e0); end
    n_checks++;
    if (t < TMO + FILT + 1 || t > TMO + FILT + 3) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d required %0d..%0d", t, TMO + FILT + 1, TMO + FILT + 3);
    end
    // The timeout must have dropped the pending E0, so a bare 72 is not Down.
    send_byte(8'h72, 1'b0);
    n_checks++; if (down_key !== 1'b0) begin n_fail++; $display("FAIL timeout_prefix_cleared: got %b required 0", down_key); end
    n_checks++; if ({keycode_ext, keycode} !== 9'h072) begin n_fail++; $display("FAIL timeout_bare_keycode: got %h required 072", {keycode_ext, keycode}); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h72, 1'b0);
    n_checks++; if (down_key !== 1'b1) begin n_fail++; $display("FAIL timeout_down_key: got %b required 1", down_key); end
    n_checks++; if ({keycode_ext, keycode} !== 9'h172) begin n_fail++; $display("FAIL timeout_down_keycode: got %h required 172", {keycode_ext, keycode}); end
  endtask

  task automatic test_multi_bat;
    send_byte(8'h1D, 1'b0);
    send_byte(8'h29, 1'b0);
    n_checks++; if (keys !== 5'b11011) begin n_fail++; $display("FAIL multi_keys: got %b required 11011", keys); end
    send_byte(8'hAA, 1'b0);
    n_checks++; if (keys !== 5'b00000) begin n_fail++; $display("FAIL bat_clear: got %b required 00000", keys); end
    n_checks++; if ({keycode_ext, keycode} !== 9'h0AA) begin n_fail++; $display("FAIL bat_keycode: got %h required 0aa", {keycode_ext, keycode}); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_byte(8'h1D, 1'b0);
    send_byte(8'h1D, 1'b0);
    n_checks++; if (w_key !== 1'b1) begin n_fail++; $display("FAIL typematic_w_key: got %b required 1", w_key); end
    n_checks++; if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL typematic_valid_count: got %0d required 2", n_valid - v0); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1B, 1'b0);
    n_checks++; if (keys !== 5'b10000) begin n_fail++; $display("FAIL break_unheld_keys: got %b required 10000", keys); end
    v0 = n_valid;
    send_byte(8'h1C, 1'b0);
    n_checks++; if (keys !== 5'b10000) begin n_fail++; $display("FAIL unmapped_keys: got %b required 10000", keys); end
    n_checks++; if ({keycode_ext, keycode} !== 9'h01C) begin n_fail++; $display("FAIL unmapped_keycode: got %h required 01c", {keycode_ext, keycode}); end
    n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL unmapped_valid_count: got %0d required 1", n_valid - v0); end
  endtask

  task automatic test_reset_midframe;
    int e0;
    logic [7:0]  b;
    logic [10:0] fr;
    b  = 8'h29;
    fr = {1'b1, ~^b, b, 1'b0};
    e0 = n_err;
    send_bits(fr, 4);
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if ({keys, keycode, keycode_ext, keycode_valid, frame_err} !== 16'h0000) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: got %h required 0000",
               {keys, keycode, keycode_ext, keycode_valid, frame_err});
    end
    Reset = 1'b0;
    repeat (TMO + 50) @(negedge Clk);
    n_checks++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL midframe_reset_no_err: got %0d required 0", n_err - e0); end
    send_byte(8'h29, 1'b0);
    n_checks++; if (space_key !== 1'b1) begin n_fail++; $display("FAIL post_reset_space: got %b required 1", space_key); end
    n_checks++; if ({keycode_ext, keycode} !== 9'h029) begin n_fail++; $display("FAIL post_reset_keycode: got %h required 029", {keycode_ext, keycode}); end
  endtask

  initial begin
    Reset   = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    @(negedge Clk);
    test_reset;
    test_make_w;
    test_break_w;
    test_ext_up;
    test_parity_err;
    test_timeout;
    test_multi_bat;
    test_back_to_back;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
